// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a 16-bit synchronous memory.
// Each transaction takes three cycles: IDLE (arbitrate), CMD (memory access), RESP (capture).
module mem_arbiter #(
    parameter int ADDRESS_SIZE = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    p0_req,
    input  logic                    p0_we,
    input  logic [ADDRESS_SIZE-1:0] p0_addr,
    input  logic [15:0]             p0_wdata,
    output logic                    p0_gnt,
    output logic                    p0_done,
    output logic [15:0]             p0_rdata,
    input  logic                    p1_req,
    input  logic                    p1_we,
    input  logic [ADDRESS_SIZE-1:0] p1_addr,
    input  logic [15:0]             p1_wdata,
    output logic                    p1_gnt,
    output logic                    p1_done,
    output logic [15:0]             p1_rdata,
    output logic [ADDRESS_SIZE-1:0] mem_address,
    output logic                    mem_load,
    output logic                    mem_out_en,
    output logic [15:0]             mem_data_in,
    input  logic [15:0]             mem_data_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic                    any_req_s;
    logic                    winner_s;
    logic                    sel_we_s;
    logic [ADDRESS_SIZE-1:0] sel_addr_s;
    logic [15:0]             sel_wdata_s;

    logic                    owner_r;
    logic                    last_r;
    logic                    we_r;
    logic [ADDRESS_SIZE-1:0] addr_r;
    logic [15:0]             wdata_r;
    logic                    load_r;
    logic                    rd_en_r;
    logic                    p0_gnt_r;
    logic                    p1_gnt_r;
    logic                    p0_done_r;
    logic                    p1_done_r;
    logic [15:0]             p0_rdata_r;
    logic [15:0]             p1_rdata_r;

    // Winner selection: a lone requester wins; on a tie the port that did not win last time wins.
    always_comb begin
        any_req_s   = p0_req | p1_req;
        winner_s    = 1'b0;
        if (p0_req && p1_req) begin
            winner_s = ~last_r;
        end else if (p1_req) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
        sel_we_s    = winner_s ? p1_we    : p0_we;
        sel_addr_s  = winner_s ? p1_addr  : p0_addr;
        sel_wdata_s = winner_s ? p1_wdata : p0_wdata;
    end

    // Next-state logic: CMD and RESP each last exactly one cycle.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = any_req_s ? CMD : IDLE;
            CMD:     state_s = RESP;
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, command latches and registered port/memory strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            owner_r    <= 1'b0;
            last_r     <= 1'b1;
            we_r       <= 1'b0;
            addr_r     <= {ADDRESS_SIZE{1'b0}};
            wdata_r    <= 16'h0000;
            load_r     <= 1'b0;
            rd_en_r    <= 1'b0;
            p0_gnt_r   <= 1'b0;
            p1_gnt_r   <= 1'b0;
            p0_done_r  <= 1'b0;
            p1_done_r  <= 1'b0;
            p0_rdata_r <= 16'h0000;
            p1_rdata_r <= 16'h0000;
        end else begin
            state_r   <= state_s;
            load_r    <= 1'b0;
            rd_en_r   <= 1'b0;
            p0_gnt_r  <= 1'b0;
            p1_gnt_r  <= 1'b0;
            p0_done_r <= 1'b0;
            p1_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (any_req_s) begin
                        owner_r  <= winner_s;
                        last_r   <= winner_s;
                        we_r     <= sel_we_s;
                        addr_r   <= sel_addr_s;
                        wdata_r  <= sel_wdata_s;
                        load_r   <= sel_we_s;
                        rd_en_r  <= ~sel_we_s;
                        p0_gnt_r <= ~winner_s;
                        p1_gnt_r <= winner_s;
                    end
                end
                RESP: begin
                    p0_done_r <= ~owner_r;
                    p1_done_r <= owner_r;
                    // Memory data_out is valid during RESP after the access at the end of CMD.
                    if (!we_r) begin
                        if (owner_r) begin
                            p1_rdata_r <= mem_data_out;
                        end else begin
                            p0_rdata_r <= mem_data_out;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign p0_gnt      = p0_gnt_r;
    assign p1_gnt      = p1_gnt_r;
    assign p0_done     = p0_done_r;
    assign p1_done     = p1_done_r;
    assign p0_rdata    = p0_rdata_r;
    assign p1_rdata    = p1_rdata_r;
    assign mem_address = addr_r;
    assign mem_data_in = wdata_r;
    // Gated by reset so the memory commits nothing on the edge that aborts a transaction.
    assign mem_load    = load_r & ~reset;
    assign mem_out_en  = rd_en_r & ~reset;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the 16-bit synchronous `memory` block.
- Port 0 is instruction fetch; port 1 is data load/store.
- Grants one transaction at a time, round-robin. Drives the memory's address/load/out_en/data_in and returns read data with a done pulse.
- Sole master of the memory's control pins; the memory reads and writes on its own clock edge.

Parameters:
ADDRESS_SIZE, 16, width of port and memory addresses (matches memory address_size)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
p0_req  in  1  port 0 request; held with p0_we/p0_addr/p0_wdata stable until p0_gnt seen
p0_we  in  1  port 0: 1 = write, 0 = read
p0_addr  in  ADDRESS_SIZE  port 0 address
p0_wdata  in  16  port 0 write data
p0_gnt  out  1  port 0 request accepted (one-cycle pulse)
p0_done  out  1  port 0 transaction complete (one-cycle pulse)
p0_rdata  out  16  port 0 read data, valid with p0_done on reads, held afterwards
p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_done, p1_rdata: same as port 0, for port 1
mem_address  out  ADDRESS_SIZE  to memory address
mem_load  out  1  to memory load (write strobe)
mem_out_en  out  1  to memory out_en (read enable)
mem_data_in  out  16  to memory data_in
mem_data_out  in  16  from memory data_out

Behaviour:
- Interface: one clock (`clk`). `reset` is synchronous and active-high.
- FSM states: IDLE, CMD, RESP. Reset state is IDLE.
- IDLE:
  - If any req is high at the rising edge, select a winner.
  - Latch the winner's we/addr/wdata into cmd registers and record it in `owner`.
  - Go to CMD. Otherwise stay in IDLE.
- Winner selection:
  - Only one req high: that port wins.
  - Both high: the port other than `last` wins; `last` is then updated to the winner.
  - `last` resets to 1, so port 0 wins the first tie.
- CMD (exactly 1 cycle):
  - pN_gnt = 1 for the owner.
  - mem_address = latched addr; mem_data_in = latched wdata.
  - mem_load = we_q; mem_out_en = ~we_q.
  - Memory performs the access at the edge that ends CMD.
  - Next state: RESP.
- RESP (exactly 1 cycle):
  - mem_load = 0, mem_out_en = 0.
  - On a read, load mem_data_out into the owner's pN_rdata at the edge that ends RESP.
  - Next state: IDLE. pN_done = 1 for the owner during the following cycle (registered pulse).
- Outside CMD:
  - mem_load = 0 and mem_out_en = 0.
  - mem_address and mem_data_in hold their last latched values.
- Latency, with req sampled at edge E0:
  - gnt high in cycle E0+1.
  - done and rdata valid in cycle E0+3.
  - Throughput is one transaction per 3 cycles.
  - A new request may be sampled in the same IDLE cycle in which the previous done is high.
- Requester rule:
  - Deassert req (or present the next request) at the edge that ends the gnt cycle.
  - req is not sampled in CMD or RESP, so a req held through RESP is treated as a new request.
- Write transactions: pN_done pulses; pN_rdata is unchanged.
- pN_rdata holds its value until the next read completion on that port.
- Reset:
  - mem_load and mem_out_en are gated with ~reset combinationally, so no memory write or read is committed in any reset cycle.
  - At the edge: state = IDLE, last = 1.
  - Outputs return to reset values: all gnt/done 0, rdata 0, mem_address 0, mem_data_in 0.
  - An in-flight transaction is aborted with no done.
- Owner drives done/gnt/rdata; the other port's gnt/done stay 0.

Test Plan:
- Write then read, single port: mem[0x0010] = 0x0000. p1 write addr 0x0010, data 0xBEEF → p1_gnt in cycle 1, mem_load = 1 only in cycle 1, p1_done in cycle 3. Then p1 read 0x0010 → mem_out_en = 1 for one cycle, p1_rdata = 0xBEEF with p1_done.
- Tie after reset: p0 read 0x0001 and p1 read 0x0002 raised together, both held → grant order p0, p1, p0, p1. Each gnt is 3 cycles apart; p1_gnt never coincides with p0_gnt.
- Fairness: p0_req continuously high with new addresses; p1_req raised → p1 granted at the very next IDLE. Port 0 is never granted twice in a row while p1_req is pending.
- Data isolation: p0 reads 0x1234 from addr 5, then p1 reads 0x5678 from addr 6 → p0_rdata stays 0x1234, p1_rdata = 0x5678, each done only on its own port.
- Reset mid-write: p0 write addr 7 = 0xAAAA, reset asserted during the CMD cycle → mem_load = 0 that cycle, no p0_done. A following read of addr 7 returns the prior value (0x0000). All outputs are 0 the cycle after reset.
- Idle: no requests for 10 cycles → mem_load = 0, mem_out_en = 0, all gnt/done 0 throughout.
